// File: rtl/block_read_engine_pkg.sv
// Shared types and defaults for the block-read sequencer and its timeout counter.
package block_read_engine_pkg;

    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned DEFAULT_CNT_W   = 9;
    localparam int unsigned DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_PUSH = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/block_read_engine_rd_timeout_counter.sv
// Per-quadlet wait counter: counts enabled cycles since the last clear and
// flags the last cycle allowed before the read is declared lost.
module rd_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter value k means k+1 cycles have been spent waiting once this one ends.
    assign expired_c = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_c) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/block_read_engine.sv
// Walks a contiguous quadlet range, waits for read-valid on each address and
// streams the captured words to a packet builder over valid/ready.
module block_read_engine
    import block_read_engine_pkg::*;
#(
    parameter int unsigned CNT_W   = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              abort,
    output logic [ADDR_W-1:0] reg_raddr,
    input  logic              reg_rvalid,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              tmo_clear, tmo_en, tmo_expired;

    rd_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk       (sysclk),
        .rst       (reset),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_en),
        .expired_c (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        err_d       = err_q;
        remaining_d = remaining_q;
        tmo_clear   = 1'b0;
        tmo_en      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (count != '0) begin
                        raddr_d     = base_addr;
                        remaining_d = count;
                        tmo_clear   = 1'b1;
                        state_d     = S_WAIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end else if (reg_rvalid) begin
                    data_d    = reg_rdata;
                    valid_d   = 1'b1;
                    tmo_clear = 1'b1;
                    state_d   = S_PUSH;
                end else if (tmo_expired) begin
                    err_d     = 1'b1;
                    tmo_clear = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            S_PUSH: begin
                // Abort beats a same-cycle handshake: the word is treated as undelivered.
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                        raddr_d     = raddr_q + ADDR_W'(1);
                        tmo_clear   = 1'b1;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            raddr_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            remaining_q <= remaining_d;
        end
    end

    assign reg_raddr = raddr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/block_read_engine.md
Name: block_read_engine

Overview:
- Sequencer downstream of the read-data-valid logic: drives reg_raddr through a contiguous quadlet range, waits on reg_rvalid for each address, and streams captured reg_rdata to a packet builder (Firewire/Ethernet block-read response) over a valid/ready handshake.
- Handles both zero-wait (register) and one-wait (memory) read sources transparently.
- Bounded per-quadlet wait with timeout error.

Parameters:
- CNT_W, 9, width of quadlet count (max 256 quadlets; count value 256 legal).
- TIMEOUT, 15, max sysclk cycles in S_WAIT before aborting with error.

Ports:
- sysclk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request; sampled only in S_IDLE
- base_addr  input  16  first register address
- count  input  CNT_W  number of quadlets to read
- abort  input  1  terminate current transfer
- reg_raddr  output  16  register read address (registered)
- reg_rvalid  input  1  read data valid for current reg_raddr
- reg_rdata  input  32  register read data
- out_data  output  32  captured quadlet
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high in every state except S_IDLE
- done  output  1  one-cycle pulse at end of transfer (normal, abort or timeout)
- err  output  1  sticky timeout flag; cleared by next accepted start

Behaviour:
- Reset (async): state S_IDLE; reg_raddr=0, out_data=0, out_valid=0, busy=0, done=0, err=0, remaining=0, wait counter=0.
- S_IDLE: start=1 and count!=0 -> latch reg_raddr<=base_addr, remaining<=count, err<=0, go S_WAIT. start=1 and count==0 -> err<=0, done pulse next cycle, stay S_IDLE, no reads. start while busy ignored.
- S_WAIT: wait counter increments each cycle. reg_rvalid=1 -> out_data<=reg_rdata, out_valid<=1, counter<=0, go S_PUSH.
  - reg_rvalid is sampled no earlier than the first cycle after reg_raddr updates, so zero-wait sources complete S_WAIT in 1 cycle and one-wait sources in 2 cycles.
  - Counter reaches TIMEOUT with no reg_rvalid -> err<=1, go S_DONE.
- S_PUSH: out_valid held high with out_data stable until out_ready=1. On acceptance, out_valid<=0 and:
  - remaining==1 -> go S_DONE;
  - else remaining<=remaining-1, reg_raddr<=reg_raddr+1 (16-bit wrap, 0xFFFF->0x0000), go S_WAIT.
- S_DONE: done=1 for exactly one cycle, busy=0 next cycle, go S_IDLE. reg_raddr keeps its last value.
- abort (any non-idle state, highest priority): out_valid<=0 immediately, go S_DONE. err is unchanged. A quadlet in S_PUSH not yet accepted is dropped. abort in S_IDLE has no effect.
- Simultaneous abort and out_ready in S_PUSH: abort wins, and the quadlet counts as not delivered.
- Throughput: one quadlet per 2 cycles (zero-wait) or 3 cycles (one-wait) with out_ready held high.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding (S_IDLE, S_WAIT, S_PUSH, S_DONE), default TIMEOUT constant.
- Sub-module: one natural sub-module, rd_timeout_counter (clear/enable, TIMEOUT compare, expired output).
- Bench instantiates the existing read-data-valid block between reg_raddr and reg_rvalid.

Test Plan:
- Zero-wait source, base=0x0010, count=4, out_ready=1 -> out_data = mem[0x10..0x13] in order, 4 handshakes, done at cycle ~9 after start, err=0.
- One-wait source (rvalid one cycle after address change), base=0x4000, count=3 -> 3 correct quadlets, 3 cycles/quadlet, no quadlet captured with stale data.
- Backpressure: out_ready low 5 cycles during quadlet 2 of count=3 -> out_data/out_valid stable throughout, reg_raddr unchanged, all 3 delivered.
- Wrap and max count: base=0xFFFE, count=3 -> addresses 0xFFFE, 0xFFFF, 0x0000. Separately, count=256 -> 256 quadlets delivered.
- Timeout: rvalid forced 0 -> err=1 and done after TIMEOUT cycles in S_WAIT. Next start clears err.
- Edge controls: count=0 -> done pulse, no reads. abort mid-S_PUSH with out_ready=1 -> quadlet dropped, done next cycle. Reset asserted mid-transfer -> all outputs 0 immediately. start while busy -> ignored.
